alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1, instruction offered.
REQ-004 SHALL have port in_ready, output, 1, sequencer can accept an instruction.
REQ-005 SHALL have port in_instr, input, 16: [15:12] opcode, [11:8] dest, [7:4] src, [3:0] ignored.
REQ-006 SHALL have ports ld_we (input, 1), ld_addr (input, 4) and ld_data (input, 16): host register preload.
REQ-007 SHALL have ports dbg_addr (input, 4) and dbg_data (output, 16): combinational register read.
REQ-008 SHALL have ports alu_a, alu_b (output, 16), alu_op (output, 5) and alu_cin (output, 1): drive the ALU.
REQ-009 SHALL have ports alu_y (input, 16) and alu_z, alu_n, alu_c, alu_v (input, 1 each): ALU results.
REQ-010 SHALL have port flags, output, 4: {N,Z,C,V} status register.
REQ-011 SHALL have ports done (output, 1), one-cycle retire pulse, and illegal (output, 1), one-cycle pulse with done for opcode 15.

Function
REQ-012 SHALL implement FSM IDLE->READ->EXEC->WB->IDLE; in_ready=1 only in IDLE; acceptance = in_valid&&in_ready.
REQ-013 SHALL latch instr in IDLE on acceptance; latch regs[dest] to A-operand and regs[src] to B-operand in READ.
REQ-014 SHALL hold alu_a, alu_b, alu_op, alu_cin stable throughout EXEC; capture alu_y/alu_z/n/c/v at end of EXEC.
REQ-015 SHALL write back and update flags in WB, with done=1 in WB; acceptance-to-done latency exactly 3 cycles; peak throughput one instruction per 4 cycles.
REQ-016 SHALL drive alu_op={1'b0,opcode} for opcodes 0-12; opcode 13 (MOV) and 14 (CMP) SHALL drive alu_op=5'b00010 (SUB) for CMP and 5'b00101 (OR) with alu_a=0 for MOV.
REQ-017 SHALL drive alu_cin=flags.C (C register) in EXEC; 0 outside EXEC; alu_a/alu_b/alu_op SHALL be 0 outside EXEC.
REQ-018 Flags: ADD/ADC/SUB/SBC/CMP update N,Z,C,V; AND/OR/XOR/NOT/MOV update N,Z only (C,V held); shifts/rotates update N,Z,C (V held).
REQ-019 Writeback: regs[dest]=alu_y for opcodes 0-13; CMP (14) writes nothing.
REQ-020 Opcode 15: no writeback, no flag change, illegal=1 in WB with done.
REQ-021 ld_we SHALL write regs[ld_addr]=ld_data only in IDLE; ignored in READ/EXEC/WB.
REQ-022 ld_we and acceptance in the same IDLE cycle: load performed; the accepted instruction reads the loaded value in READ.
REQ-023 dest==src SHALL be legal: both operands equal the same register value.
REQ-024 in_valid held across WB->IDLE: the next instruction SHALL be accepted in the first IDLE cycle and SHALL see the just-written register and flags.

Reset
REQ-025 rst asserted SHALL force IDLE, clear all 16 registers, flags=0, done=0, illegal=0 and ALU drive outputs=0, immediately and asynchronously.
REQ-026 On reset mid-instruction, the in-flight instruction SHALL be abandoned with no writeback and no flag change.
REQ-027 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-028 A shared package SHALL hold the ALUop localparams (ADD..ROR), MOV/CMP/ILLEGAL opcode constants, FSM state encoding and the flag bit indices.
REQ-029 The 16x16 register file SHALL be a sub-module named regfile, with 1 write port and 3 asynchronous read ports (dest, src, dbg).
REQ-030 The ALU SHALL be instantiated outside this block and connected to it.

Verification
REQ-031 Load R1=0x7FFF, R2=0x0001; ADD R1,R2 -> after 3 cycles done=1, R1=0x8000, flags N=1 Z=0 C=0 V=1.
REQ-032 Load R3=0x0005; CMP R3,R3 -> R3 unchanged 0x0005, flags Z=1 C=1 N=0 V=0.
REQ-033 Flags C=1 from a prior op, R4=0x8001; ROR R4 -> R4=0xC000, C=1, N=1; then AND R4,R4 -> C still 1.
REQ-034 Opcode 15 -> done=1 and illegal=1 same cycle; registers and flags unchanged.
REQ-035 Assert rst during EXEC of ADD R1,R2 -> R1=0 and flags=0 after reset; in_ready=1 first cycle after release.
REQ-036 Back-to-back in_valid: MOV R5,R1 (R1=0x1234) then XOR R5,R1 -> second accepted 4 cycles after first; R5=0x0000, Z=1.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared ALU op codes, opcode constants, FSM states and flag helpers
package alu_sequencer_pkg;

  // ALU operation codes driven on alu_op
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_ADC = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_SBC = 5'd3;
  localparam logic [4:0] ALU_AND = 5'd4;
  localparam logic [4:0] ALU_OR  = 5'd5;
  localparam logic [4:0] ALU_XOR = 5'd6;
  localparam logic [4:0] ALU_NOT = 5'd7;
  localparam logic [4:0] ALU_SHL = 5'd8;
  localparam logic [4:0] ALU_SHR = 5'd9;
  localparam logic [4:0] ALU_SAR = 5'd10;
  localparam logic [4:0] ALU_ROL = 5'd11;
  localparam logic [4:0] ALU_ROR = 5'd12;

  // Instruction opcodes that do not map straight onto an ALU op
  localparam logic [3:0] OP_MOV     = 4'd13;
  localparam logic [3:0] OP_CMP     = 4'd14;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Bit positions inside the {N,Z,C,V} status register
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Merge ALU status into the current flags according to the opcode class
  function automatic logic [3:0] next_flags(input logic [3:0] opcode, input logic [3:0] cur,
                                            input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f = cur;
    if (opcode != OP_ILLEGAL) begin
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      if (opcode <= ALU_SBC[3:0] || opcode == OP_CMP) begin
        f[FLAG_C] = c;
        f[FLAG_V] = v;
      end else if (opcode >= ALU_SHL[3:0] && opcode <= ALU_ROR[3:0]) begin
        f[FLAG_C] = c;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// rtl/alu_sequencer_regfile.sv - 16x16 register file, one write port, three async read ports
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [3:0]  raddr0,
  output logic [15:0] rdata0,
  input  logic [3:0]  raddr1,
  output logic [15:0] rdata1,
  input  logic [3:0]  raddr2,
  output logic [15:0] rdata2
);

  logic [15:0] regs [16];

  // Single write port; whole array clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Asynchronous read ports
  always_comb begin
    rdata0 = regs[raddr0];
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state sequencer driving an external ALU over a 16x16 register file
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic        ld_we,
  input  logic [3:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_y,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic [3:0]  flags,
  output logic        done,
  output logic        illegal
);

  state_t      state, state_nxt;
  logic [11:0] instr_q;
  logic [15:0] a_q, b_q, y_q;
  logic        n_q, z_q, c_q, v_q;
  logic [3:0]  flags_q;
  logic [15:0] rd_dest, rd_src;
  logic        accept;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        unused_bits;

  logic [3:0] opcode, dest, src;
  assign opcode      = instr_q[11:8];
  assign dest        = instr_q[7:4];
  assign src         = instr_q[3:0];
  assign accept      = in_valid && in_ready;
  assign flags       = flags_q;
  assign unused_bits = ^in_instr[3:0];

  // Host preload only in IDLE; writeback only in WB, so the two never collide
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 4'd0;
    rf_wdata = 16'h0000;
    if (state == ST_IDLE && ld_we) begin
      rf_we    = 1'b1;
      rf_waddr = ld_addr;
      rf_wdata = ld_data;
    end else if (state == ST_WB && opcode < OP_CMP) begin
      rf_we    = 1'b1;
      rf_waddr = dest;
      rf_wdata = y_q;
    end
  end

  regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr0 (dest),
    .rdata0 (rd_dest),
    .raddr1 (src),
    .rdata1 (rd_src),
    .raddr2 (dbg_addr),
    .rdata2 (dbg_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/retire outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_READ;
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB: begin
        done      = 1'b1;
        illegal   = (opcode == OP_ILLEGAL);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Instruction latch on acceptance, operand latch in READ, ALU result capture at end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= 12'h000;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      y_q     <= 16'h0000;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      if (accept) instr_q <= in_instr[15:4];
      if (state == ST_READ) begin
        a_q <= rd_dest;
        b_q <= rd_src;
      end
      if (state == ST_EXEC) begin
        y_q <= alu_y;
        n_q <= alu_n;
        z_q <= alu_z;
        c_q <= alu_c;
        v_q <= alu_v;
      end
    end
  end

  // Status register commits together with the writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                flags_q <= 4'h0;
    else if (state == ST_WB) flags_q <= next_flags(opcode, flags_q, n_q, z_q, c_q, v_q);
  end

  // ALU drive: quiet outside EXEC; MOV becomes 0|src, CMP becomes a discarded SUB
  always_comb begin
    alu_a   = 16'h0000;
    alu_b   = 16'h0000;
    alu_op  = 5'd0;
    alu_cin = 1'b0;
    if (state == ST_EXEC) begin
      alu_a   = a_q;
      alu_b   = b_q;
      alu_op  = {1'b0, opcode};
      alu_cin = flags_q[FLAG_C];
      if (opcode == OP_MOV) begin
        alu_a  = 16'h0000;
        alu_op = ALU_OR;
      end else if (opcode == OP_CMP) begin
        alu_op = ALU_SUB;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench with a behavioural external ALU
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        ld_we;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [4:0]  alu_op;
  logic        alu_cin, alu_z, alu_n, alu_c, alu_v;
  logic [3:0]  flags;
  logic        done, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .flags(flags), .done(done), .illegal(illegal)
  );

  // Behavioural external ALU; C on subtract means no borrow
  logic [16:0] sum;
  always_comb begin
    sum   = 17'h0;
    alu_y = 16'h0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      5'd0, 5'd1: begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b} + ((alu_op == 5'd1) ? {16'h0, alu_cin} : 17'h0);
        alu_y = sum[15:0];
        alu_c = sum[16];
        alu_v = (alu_a[15] == alu_b[15]) && (alu_y[15] != alu_a[15]);
      end
      5'd2, 5'd3: begin
        sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + ((alu_op == 5'd2) ? 17'h1 : {16'h0, alu_cin});
        alu_y = sum[15:0];
        alu_c = sum[16];
        alu_v = (alu_a[15] != alu_b[15]) && (alu_y[15] != alu_a[15]);
      end
      5'd4:  alu_y = alu_a & alu_b;
      5'd5:  alu_y = alu_a | alu_b;
      5'd6:  alu_y = alu_a ^ alu_b;
      5'd7:  alu_y = ~alu_a;
      5'd8:  begin alu_y = {alu_a[14:0], 1'b0};        alu_c = alu_a[15]; end
      5'd9:  begin alu_y = {1'b0, alu_a[15:1]};        alu_c = alu_a[0];  end
      5'd10: begin alu_y = {alu_a[15], alu_a[15:1]};   alu_c = alu_a[0];  end
      5'd11: begin alu_y = {alu_a[14:0], alu_a[15]};   alu_c = alu_a[15]; end
      5'd12: begin alu_y = {alu_a[0], alu_a[15:1]};    alu_c = alu_a[0];  end
      default: alu_y = 16'h0;
    endcase
  end
  assign alu_z = (alu_y == 16'h0);
  assign alu_n = alu_y[15];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Runs one instruction from IDLE back to IDLE, checking handshake, latency and ALU drive
  task automatic run(input string tag, input logic [15:0] instr, input logic [4:0] exp_op,
                     input logic exp_cin, input logic exp_ill);
    in_valid = 1'b1; in_instr = instr;
    #1 check({tag, " ready"}, {15'h0, in_ready}, 16'h1);
    tick();
    in_valid = 1'b0;
    check({tag, " done@1"}, {15'h0, done}, 16'h0);
    check({tag, " op idle"}, {11'h0, alu_op}, 16'h0);
    tick();
    check({tag, " done@2"}, {15'h0, done}, 16'h0);
    check({tag, " op"}, {11'h0, alu_op}, {11'h0, exp_op});
    check({tag, " cin"}, {15'h0, alu_cin}, {15'h0, exp_cin});
    tick();
    check({tag, " done@3"}, {15'h0, done}, 16'h1);
    check({tag, " illegal"}, {15'h0, illegal}, {15'h0, exp_ill});
    tick();
    check({tag, " done clr"}, {15'h0, done}, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0;
    ld_we = 1'b0; ld_addr = 4'h0; ld_data = 16'h0; dbg_addr = 4'h0;
    tick(); tick();
    check("rst flags", {12'h0, flags}, 16'h0);
    check("rst done", {15'h0, done}, 16'h0);
    rst = 1'b0;
    #1 check("rst ready", {15'h0, in_ready}, 16'h1);

    // ADD R1,R2 overflow
    load(4'd1, 16'h7FFF);
    load(4'd2, 16'h0001);
    run("add", 16'h0120, 5'd0, 1'b0, 1'b0);
    reg_chk("add r1", 4'd1, 16'h8000);
    check("add flags", {12'h0, flags}, 16'h0009);

    // CMP R3,R3
    load(4'd3, 16'h0005);
    run("cmp", 16'hE330, 5'd2, 1'b0, 1'b0);
    reg_chk("cmp r3", 4'd3, 16'h0005);
    check("cmp flags", {12'h0, flags}, 16'h0006);

    // ROR R4 then AND R4,R4 keeps C
    load(4'd4, 16'h8001);
    run("ror", 16'hC440, 5'd12, 1'b1, 1'b0);
    reg_chk("ror r4", 4'd4, 16'hC000);
    check("ror flags", {12'h0, flags}, 16'h000A);
    run("and", 16'h4440, 5'd4, 1'b1, 1'b0);
    check("and flags", {12'h0, flags}, 16'h000A);

    // Illegal opcode
    run("ill", 16'hF120, 5'd15, 1'b1, 1'b1);
    reg_chk("ill r1", 4'd1, 16'h8000);
    check("ill flags", {12'h0, flags}, 16'h000A);

    // Back-to-back MOV R5,R1 then XOR R5,R1
    load(4'd1, 16'h1234);
    in_valid = 1'b1; in_instr = 16'hD510;
    tick();
    in_instr = 16'h6510;
    check("b2b busy", {15'h0, in_ready}, 16'h0);
    tick();
    check("mov a", alu_a, 16'h0000);
    check("mov b", alu_b, 16'h1234);
    check("mov op", {11'h0, alu_op}, 16'h0005);
    tick();
    check("mov done", {15'h0, done}, 16'h1);
    tick();
    check("b2b ready", {15'h0, in_ready}, 16'h1);
    reg_chk("mov r5", 4'd5, 16'h1234);
    check("mov flags", {12'h0, flags}, 16'h0002);
    tick();
    in_valid = 1'b0;
    tick();
    check("xor b", alu_b, 16'h1234);
    tick();
    check("xor done", {15'h0, done}, 16'h1);
    tick();
    reg_chk("xor r5", 4'd5, 16'h0000);
    check("xor flags", {12'h0, flags}, 16'h0006);

    // Reset during EXEC of ADD R1,R2
    load(4'd1, 16'h7FFF);
    load(4'd2, 16'h0001);
    in_valid = 1'b1; in_instr = 16'h0120;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre-rst op", {11'h0, alu_a[4:0]}, 16'h001F);
    rst = 1'b1;
    #1;
    check("rst async op", {11'h0, alu_op}, 16'h0);
    check("rst async a", alu_a, 16'h0);
    check("rst async flags", {12'h0, flags}, 16'h0);
    tick(); tick();
    check("rst done", {15'h0, done}, 16'h0);
    rst = 1'b0;
    #1 check("rel ready", {15'h0, in_ready}, 16'h1);
    reg_chk("rst r1", 4'd1, 16'h0000);
    reg_chk("rst r2", 4'd2, 16'h0000);

    // Load and accept in the same IDLE cycle; loads ignored while busy; dest==src
    ld_we = 1'b1; ld_addr = 4'd6; ld_data = 16'h0003;
    in_valid = 1'b1; in_instr = 16'h0660;
    tick();
    in_valid = 1'b0;
    ld_addr = 4'd7; ld_data = 16'hBEEF;
    tick();
    check("same a", alu_a, 16'h0003);
    check("same b", alu_b, 16'h0003);
    tick();
    check("same done", {15'h0, done}, 16'h1);
    tick();
    ld_we = 1'b0;
    reg_chk("same r6", 4'd6, 16'h0006);
    reg_chk("busy ld r7", 4'd7, 16'h0000);
    check("same flags", {12'h0, flags}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
